// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 pin-bus responder.
// Holds the cycle classes, responder states and backend command payload.
package z80_bus_pkg;

    localparam logic [7:0]  IM2_DEFAULT_VEC = 8'hFF;
    localparam int unsigned WAIT_CNT_W      = 4;
    localparam int unsigned ADDR_W          = 16;
    localparam int unsigned DATA_W          = 8;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_MRD,
        CLS_MWR,
        CLS_IORD,
        CLS_IOWR,
        CLS_INTA
    } cycleClassE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WSETUP,
        ST_REQ,
        ST_STRETCH,
        ST_HOLD
    } respStateE;

    // Backend command presented alongside mem_req
    typedef struct packed {
        logic              we;
        logic              io;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } memCmdT;

endpackage

// File: rtl/z80_cycle_decode.sv
// Combinational classifier turning Z80 control pins into a bus cycle class.
// Refresh and bus-granted periods always classify as CLS_NONE.
module z80_cycle_decode
    import z80_bus_pkg::*;
(
    input  logic       nM1,
    input  logic       nMREQ,
    input  logic       nIORQ,
    input  logic       nRD,
    input  logic       nWR,
    input  logic       nRFSH,
    input  logic       nBUSACK,
    output cycleClassE cycleClass_c
);

    always_comb begin
        cycleClass_c = CLS_NONE;
        if (nBUSACK && nRFSH) begin
            if (!nMREQ) begin
                // nWR trails nMREQ on writes, so a memory cycle without nRD is a write
                cycleClass_c = nRD ? CLS_MWR : CLS_MRD;
            end else if (!nIORQ) begin
                if (!nM1) begin
                    cycleClass_c = CLS_INTA;
                end else if (!nRD) begin
                    cycleClass_c = CLS_IORD;
                end else if (!nWR) begin
                    cycleClass_c = CLS_IOWR;
                end
            end
        end
    end

endmodule

// File: rtl/z80_bus_responder.sv
// Z80 external-bus responder: stretches CPU cycles with nWAIT while a
// request/acknowledge backend completes, then returns read data on D.
module z80_bus_responder
    import z80_bus_pkg::*;
#(
    parameter logic [7:0]  IM2_DEFAULT = IM2_DEFAULT_VEC,
    parameter int unsigned WAIT_MIN    = 0
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        nM1,
    input  logic        nMREQ,
    input  logic        nIORQ,
    input  logic        nRD,
    input  logic        nWR,
    input  logic        nRFSH,
    input  logic        nBUSACK,
    input  logic [15:0] A,
    inout  wire  [7:0]  D,
    output logic        nWAIT,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_io,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    input  logic [7:0]  int_vec,
    input  logic        int_vec_valid,
    output logic        int_ack
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_MIN);

    cycleClassE            cycleClass_c;
    respStateE             state, stateD;
    memCmdT                cmd, cmdD;
    logic                  nWaitQ, nWaitD;
    logic                  memReqQ, memReqD;
    logic                  intAckQ, intAckD;
    logic                  dOe, dOeD;
    logic [DATA_W-1:0]     rdLatch, rdLatchD;
    logic [WAIT_CNT_W-1:0] waitCnt, waitCntD;
    logic                  aborted, abortedD;
    logic                  strobeHigh_c;
    logic                  cycleLive_c;

    z80_cycle_decode u_decode (
        .nM1          (nM1),
        .nMREQ        (nMREQ),
        .nIORQ        (nIORQ),
        .nRD          (nRD),
        .nWR          (nWR),
        .nRFSH        (nRFSH),
        .nBUSACK      (nBUSACK),
        .cycleClass_c (cycleClass_c)
    );

    assign strobeHigh_c = nMREQ && nIORQ;
    // A cycle whose strobe already rose must not get data driven back
    assign cycleLive_c  = !aborted && !strobeHigh_c;

    // State and registered outputs
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state   <= ST_IDLE;
            cmd     <= '0;
            nWaitQ  <= 1'b1;
            memReqQ <= 1'b0;
            intAckQ <= 1'b0;
            dOe     <= 1'b0;
            rdLatch <= '0;
            waitCnt <= '0;
            aborted <= 1'b0;
        end else begin
            state   <= stateD;
            cmd     <= cmdD;
            nWaitQ  <= nWaitD;
            memReqQ <= memReqD;
            intAckQ <= intAckD;
            dOe     <= dOeD;
            rdLatch <= rdLatchD;
            waitCnt <= waitCntD;
            aborted <= abortedD;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        stateD   = state;
        cmdD     = cmd;
        nWaitD   = nWaitQ;
        memReqD  = memReqQ;
        intAckD  = 1'b0;
        dOeD     = dOe;
        rdLatchD = rdLatch;
        waitCntD = waitCnt;
        abortedD = aborted;

        unique case (state)
            ST_IDLE: begin
                dOeD     = 1'b0;
                abortedD = 1'b0;
                nWaitD   = 1'b1;
                case (cycleClass_c)
                    CLS_MRD, CLS_IORD: begin
                        stateD    = ST_REQ;
                        cmdD.addr = A;
                        cmdD.we   = 1'b0;
                        cmdD.io   = (cycleClass_c == CLS_IORD);
                        memReqD   = 1'b1;
                        nWaitD    = 1'b0;
                    end
                    CLS_MWR: begin
                        stateD = ST_WSETUP;
                        nWaitD = 1'b0;
                    end
                    CLS_IOWR: begin
                        stateD     = ST_REQ;
                        cmdD.addr  = A;
                        cmdD.wdata = D;
                        cmdD.we    = 1'b1;
                        cmdD.io    = 1'b1;
                        memReqD    = 1'b1;
                        nWaitD     = 1'b0;
                    end
                    CLS_INTA: begin
                        stateD   = ST_HOLD;
                        rdLatchD = int_vec_valid ? int_vec : IM2_DEFAULT;
                        dOeD     = 1'b1;
                        intAckD  = 1'b1;
                    end
                    default: ;
                endcase
            end

            ST_WSETUP: begin
                if (strobeHigh_c) begin
                    stateD = ST_IDLE;
                    nWaitD = 1'b1;
                end else if (!nWR) begin
                    stateD     = ST_REQ;
                    cmdD.addr  = A;
                    cmdD.wdata = D;
                    cmdD.we    = 1'b1;
                    cmdD.io    = 1'b0;
                    memReqD    = 1'b1;
                end
            end

            ST_REQ: begin
                if (strobeHigh_c) begin
                    abortedD = 1'b1;
                end
                if (mem_ack) begin
                    memReqD  = 1'b0;
                    rdLatchD = mem_rdata;
                    if (WAIT_LOAD == '0) begin
                        nWaitD = 1'b1;
                        stateD = cycleLive_c ? ST_HOLD : ST_IDLE;
                        dOeD   = cycleLive_c && !cmd.we;
                    end else begin
                        stateD   = ST_STRETCH;
                        waitCntD = WAIT_LOAD;
                    end
                end
            end

            ST_STRETCH: begin
                if (strobeHigh_c) begin
                    abortedD = 1'b1;
                end
                waitCntD = waitCnt - WAIT_CNT_W'(1);
                // Leaving on the edge that counts down to zero
                if (waitCnt <= WAIT_CNT_W'(1)) begin
                    waitCntD = '0;
                    nWaitD   = 1'b1;
                    stateD   = cycleLive_c ? ST_HOLD : ST_IDLE;
                    dOeD     = cycleLive_c && !cmd.we;
                end
            end

            ST_HOLD: begin
                nWaitD = 1'b1;
                if (strobeHigh_c) begin
                    dOeD   = 1'b0;
                    stateD = ST_IDLE;
                end
            end

            default: begin
                stateD  = ST_IDLE;
                memReqD = 1'b0;
                nWaitD  = 1'b1;
                dOeD    = 1'b0;
            end
        endcase
    end

    assign D         = dOe ? rdLatch : 8'hzz;
    assign nWAIT     = nWaitQ;
    assign mem_req   = memReqQ;
    assign mem_we    = cmd.we;
    assign mem_io    = cmd.io;
    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;
    assign int_ack   = intAckQ;

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder: single-edge decode table plus
// hand-written multi-cycle sequences on WAIT_MIN=0 and WAIT_MIN=2 instances.
module tb_z80_bus_responder;

    localparam logic [6:0] P_IDLE  = 7'b1111111; // {nM1,nMREQ,nIORQ,nRD,nWR,nRFSH,nBUSACK}
    localparam logic [6:0] P_MRD   = 7'b1010111;
    localparam logic [6:0] P_M1    = 7'b0010111;
    localparam logic [6:0] P_MWR   = 7'b1011111;
    localparam logic [6:0] P_MWRW  = 7'b1011011;
    localparam logic [6:0] P_IORD  = 7'b1100111;
    localparam logic [6:0] P_IOWR  = 7'b1101011;
    localparam logic [6:0] P_INTA  = 7'b0101111;
    localparam logic [6:0] P_RFSH  = 7'b1011101;
    localparam logic [6:0] P_BUSAK = 7'b1010110;
    localparam logic [6:0] P_IORQ  = 7'b1101111;

    logic        CLK;
    logic        nRESET;
    logic        nM1, nMREQ, nIORQ, nRD, nWR, nRFSH, nBUSACK;
    logic [15:0] A;
    logic [7:0]  intVec;
    logic        intVecValid;
    logic        tbDoe;
    logic [7:0]  tbD;
    wire  [7:0]  D0;
    wire  [7:0]  D2;

    logic        nWait0, memReq0, memWe0, memIo0, intAck0, memAck0;
    logic [15:0] memAddr0;
    logic [7:0]  memWdata0, memRdata0;
    logic        nWait2, memReq2, memWe2, memIo2, intAck2, memAck2;
    logic [15:0] memAddr2;
    logic [7:0]  memWdata2, memRdata2;

    int passed = 0;
    int total  = 0;

    assign D0 = tbDoe ? tbD : 8'hzz;
    assign D2 = tbDoe ? tbD : 8'hzz;

    z80_bus_responder #(.WAIT_MIN(0)) dut0 (
        .CLK(CLK), .nRESET(nRESET), .nM1(nM1), .nMREQ(nMREQ), .nIORQ(nIORQ),
        .nRD(nRD), .nWR(nWR), .nRFSH(nRFSH), .nBUSACK(nBUSACK), .A(A), .D(D0),
        .nWAIT(nWait0), .mem_req(memReq0), .mem_we(memWe0), .mem_io(memIo0),
        .mem_addr(memAddr0), .mem_wdata(memWdata0), .mem_ack(memAck0),
        .mem_rdata(memRdata0), .int_vec(intVec), .int_vec_valid(intVecValid),
        .int_ack(intAck0)
    );

    z80_bus_responder #(.WAIT_MIN(2)) dut2 (
        .CLK(CLK), .nRESET(nRESET), .nM1(nM1), .nMREQ(nMREQ), .nIORQ(nIORQ),
        .nRD(nRD), .nWR(nWR), .nRFSH(nRFSH), .nBUSACK(nBUSACK), .A(A), .D(D2),
        .nWAIT(nWait2), .mem_req(memReq2), .mem_we(memWe2), .mem_io(memIo2),
        .mem_addr(memAddr2), .mem_wdata(memWdata2), .mem_ack(memAck2),
        .mem_rdata(memRdata2), .int_vec(intVec), .int_vec_valid(intVecValid),
        .int_ack(intAck2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [6:0]  pins;
        logic [15:0] addr;
        logic        drive;
        logic [7:0]  dval;
        logic [4:0]  expCtl;   // {nWAIT, mem_req, mem_we, mem_io, int_ack}
        logic [15:0] expAddr;
        logic [7:0]  expWdata;
    } vecT;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic checkRel(input string name, input logic [7:0] d);
        total++;
        if (d === 8'hzz || d === 8'h00) passed++;
        else $display("FAIL %s: D=%h, expected released", name, d);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic setPins(input logic [6:0] p);
        {nM1, nMREQ, nIORQ, nRD, nWR, nRFSH, nBUSACK} = p;
    endtask

    task automatic doReset();
        setPins(P_IDLE);
        tbDoe = 1'b0;
        tbD = 8'h00;
        memAck0 = 1'b0;
        memAck2 = 1'b0;
        memRdata0 = 8'h00;
        memRdata2 = 8'h00;
        nRESET = 1'b0;
        tick();
        nRESET = 1'b1;
        tick();
    endtask

    vecT vecs[10];

    initial begin
        nRESET = 1'b0;
        A = 16'h0000;
        intVec = 8'h00;
        intVecValid = 1'b0;
        doReset();

        // Reset state
        check("rst_ctl", 16'({nWait0, memReq0, memWe0, memIo0, intAck0}), 16'(5'b10000));
        check("rst_addr", memAddr0, 16'h0000);
        check("rst_wdata", 16'(memWdata0), 16'h0000);
        checkRel("rst_d", D0);

        // One-edge response from IDLE for each pin pattern
        vecs[0] = '{"mrd",    P_MRD,   16'h1234, 1'b0, 8'h00, 5'b01000, 16'h1234, 8'h00};
        vecs[1] = '{"m1",     P_M1,    16'h0038, 1'b0, 8'h00, 5'b01000, 16'h0038, 8'h00};
        vecs[2] = '{"mwr",    P_MWR,   16'h8000, 1'b1, 8'h66, 5'b00000, 16'h0000, 8'h00};
        vecs[3] = '{"iord",   P_IORD,  16'h00FE, 1'b0, 8'h00, 5'b01010, 16'h00FE, 8'h00};
        vecs[4] = '{"iowr",   P_IOWR,  16'h0012, 1'b1, 8'h5A, 5'b01110, 16'h0012, 8'h5A};
        vecs[5] = '{"inta",   P_INTA,  16'h0077, 1'b0, 8'h00, 5'b10001, 16'h0000, 8'h00};
        vecs[6] = '{"rfsh",   P_RFSH,  16'h0077, 1'b0, 8'h00, 5'b10000, 16'h0000, 8'h00};
        vecs[7] = '{"busack", P_BUSAK, 16'h0077, 1'b0, 8'h00, 5'b10000, 16'h0000, 8'h00};
        vecs[8] = '{"idle",   P_IDLE,  16'h0077, 1'b0, 8'h00, 5'b10000, 16'h0000, 8'h00};
        vecs[9] = '{"iorq",   P_IORQ,  16'h0077, 1'b0, 8'h00, 5'b10000, 16'h0000, 8'h00};
        for (int i = 0; i < 10; i++) begin
            doReset();
            A = vecs[i].addr;
            tbD = vecs[i].dval;
            tbDoe = vecs[i].drive;
            setPins(vecs[i].pins);
            tick();
            check({vecs[i].name, "_ctl"}, 16'({nWait0, memReq0, memWe0, memIo0, intAck0}),
                  16'(vecs[i].expCtl));
            check({vecs[i].name, "_addr"}, memAddr0, vecs[i].expAddr);
            check({vecs[i].name, "_wdata"}, 16'(memWdata0), 16'(vecs[i].expWdata));
        end

        // MRD with ack three cycles after request
        doReset();
        A = 16'h1234;
        setPins(P_MRD);
        tick();
        check("a_start", 16'({nWait0, memReq0, memWe0, memIo0}), 16'(4'b0100));
        check("a_addr", memAddr0, 16'h1234);
        tick();
        check("a_wait1", 16'({nWait0, memReq0}), 16'(2'b01));
        tick();
        check("a_wait2", 16'({nWait0, memReq0}), 16'(2'b01));
        memAck0 = 1'b1;
        memRdata0 = 8'hA5;
        tick();
        memAck0 = 1'b0;
        memRdata0 = 8'h00;
        check("a_done", 16'({nWait0, memReq0}), 16'(2'b10));
        check("a_data", 16'(D0), 16'h00A5);
        tick();
        check("a_hold", 16'(D0), 16'h00A5);
        setPins(P_IDLE);
        tick();
        checkRel("a_release", D0);

        // MWR: request waits for nWR, DUT never drives D
        doReset();
        A = 16'h8000;
        tbD = 8'h3C;
        tbDoe = 1'b1;
        setPins(P_MWR);
        tick();
        check("b_setup", 16'({nWait0, memReq0}), 16'(2'b00));
        tick();
        check("b_setup2", 16'({nWait0, memReq0}), 16'(2'b00));
        setPins(P_MWRW);
        tick();
        check("b_req", 16'({nWait0, memReq0, memWe0, memIo0}), 16'(4'b0110));
        check("b_addr", memAddr0, 16'h8000);
        check("b_wdata", 16'(memWdata0), 16'h003C);
        memAck0 = 1'b1;
        memRdata0 = 8'hC3;
        tick();
        memAck0 = 1'b0;
        check("b_done", 16'({nWait0, memReq0}), 16'(2'b10));
        check("b_bus", 16'(D0), 16'h003C);
        setPins(P_IDLE);
        tbDoe = 1'b0;
        tick();
        checkRel("b_release", D0);

        // IORD on the WAIT_MIN=2 instance with immediate ack
        doReset();
        A = 16'h00FE;
        setPins(P_IORD);
        tick();
        check("c_start", 16'({nWait2, memReq2, memWe2, memIo2}), 16'(4'b0101));
        check("c_addr", memAddr2, 16'h00FE);
        memAck2 = 1'b1;
        memRdata2 = 8'h7F;
        tick();
        memAck2 = 1'b0;
        check("c_ack", 16'({nWait2, memReq2}), 16'(2'b00));
        tick();
        check("c_stretch", 16'(nWait2), 16'h0000);
        tick();
        check("c_done", 16'(nWait2), 16'h0001);
        check("c_data", 16'(D2), 16'h007F);
        setPins(P_IDLE);
        tick();
        checkRel("c_release", D2);

        // INTA with default vector, then with a supplied vector
        doReset();
        intVec = 8'h40;
        intVecValid = 1'b0;
        setPins(P_INTA);
        tick();
        check("d_vec_dflt", 16'(D0), 16'h00FF);
        check("d_ctl", 16'({nWait0, memReq0, intAck0}), 16'(3'b101));
        tick();
        check("d_ack_once", 16'({nWait0, memReq0, intAck0}), 16'(3'b100));
        check("d_vec_hold", 16'(D0), 16'h00FF);
        setPins(P_IDLE);
        tick();
        checkRel("d_release", D0);
        intVecValid = 1'b1;
        setPins(P_INTA);
        tick();
        check("d_vec_ext", 16'(D0), 16'h0040);
        check("d_ack2", 16'(intAck0), 16'h0001);
        tick();
        check("d_ack2_once", 16'(intAck0), 16'h0000);
        setPins(P_IDLE);
        tick();
        checkRel("d_release2", D0);

        // Strobe rises during REQ, then during WSETUP
        doReset();
        A = 16'h4000;
        setPins(P_MRD);
        tick();
        check("f_req", 16'(memReq0), 16'h0001);
        setPins(P_IDLE);
        tick();
        check("f_req_held", 16'(memReq0), 16'h0001);
        memAck0 = 1'b1;
        memRdata0 = 8'h99;
        tick();
        memAck0 = 1'b0;
        check("f_done", 16'({nWait0, memReq0}), 16'(2'b10));
        checkRel("f_nodrive", D0);
        tick();
        checkRel("f_nodrive2", D0);
        setPins(P_MWR);
        tick();
        check("f_wsetup", 16'({nWait0, memReq0}), 16'(2'b00));
        setPins(P_IDLE);
        tick();
        check("f_wabort", 16'({nWait0, memReq0}), 16'(2'b10));
        tick();
        check("f_wnoreq", 16'({nWait0, memReq0}), 16'(2'b10));

        // Asynchronous reset during REQ and during HOLD
        doReset();
        A = 16'h2222;
        setPins(P_MRD);
        tick();
        check("e_req", 16'(memReq0), 16'h0001);
        #1 nRESET = 1'b0;
        #1;
        check("e_rst_ctl", 16'({nWait0, memReq0}), 16'(2'b10));
        checkRel("e_rst_d", D0);
        setPins(P_IDLE);
        tick();
        nRESET = 1'b1;
        tick();
        A = 16'h00AA;
        setPins(P_MRD);
        tick();
        check("e_again", 16'({nWait0, memReq0}), 16'(2'b01));
        check("e_addr", memAddr0, 16'h00AA);
        memAck0 = 1'b1;
        memRdata0 = 8'h5A;
        tick();
        memAck0 = 1'b0;
        check("e_data", 16'(D0), 16'h005A);
        check("e_done", 16'({nWait0, memReq0}), 16'(2'b10));
        #1 nRESET = 1'b0;
        #1;
        checkRel("e_rst_hold_d", D0);
        setPins(P_IDLE);
        tick();
        nRESET = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
